// File: rtl/diferential_muxpga_loader.sv
// Purpose: clears a MUX-based FPGA fabric, shifts NCFG config nibbles into its chain,
//          then runs it for a latched number of cycles and captures its output byte.
// Latency: 1 (CLEAR) + NCFG accepted nibbles + run_cycles + 1 (DONE) cycles from start edge to done.
// Backpressure: cfg_ready is high only in LOAD; cfg_valid is ignored elsewhere, and stalls in LOAD hold the fabric.
// Ports: clk/reset (async active-low); start/run_cycles launch a sequence; cfg_valid/cfg_nibble/cfg_ready
//        feed the config stream; data_in, fab_* drive/observe the fabric; result, busy, done report status.
module diferential_muxpga_loader #(
    parameter int NCFG  = 24,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [RUN_W-1:0] run_cycles,
    input  logic             cfg_valid,
    input  logic [3:0]       cfg_nibble,
    output logic             cfg_ready,
    input  logic [3:0]       data_in,
    output logic             fab_reset,
    output logic [1:0]       fab_cmd,
    output logic [3:0]       fab_nibble,
    input  logic [7:0]       fab_out,
    output logic [7:0]       result,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(NCFG + 1);
    localparam logic [CNT_W-1:0] LAST_CFG = CNT_W'(NCFG - 1);

    localparam logic [1:0] CMD_SHIFT = 2'd0;
    localparam logic [1:0] CMD_RUN   = 2'd1;
    localparam logic [1:0] CMD_HOLD  = 2'd2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOAD  = 3'd2,
        RUN   = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cfg_cnt;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_lat;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Counters, run-length latch and captured result.
    // run_cnt only ever reaches run_lat (at most 2^RUN_W-1), so it never wraps.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cfg_cnt <= '0;
            run_cnt <= '0;
            run_lat <= '0;
            result  <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    cfg_cnt <= '0;
                    run_cnt <= '0;
                    if (start) begin
                        run_lat <= run_cycles;
                    end
                end
                LOAD: begin
                    if (cfg_valid) begin
                        cfg_cnt <= cfg_cnt + CNT_W'(1);
                    end
                end
                RUN: begin
                    run_cnt <= run_cnt + RUN_W'(1);
                    result  <= fab_out;
                end
                default: begin
                end
            endcase
        end
    end

    // Next state and combinational outputs
    always_comb begin
        state_nxt  = state;
        cfg_ready  = 1'b0;
        fab_reset  = 1'b0;
        fab_cmd    = CMD_HOLD;
        fab_nibble = 4'h0;
        busy       = 1'b1;
        done       = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                fab_reset = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                cfg_ready = 1'b1;
                if (cfg_valid) begin
                    fab_cmd    = CMD_SHIFT;
                    fab_nibble = cfg_nibble;
                    if (cfg_cnt == LAST_CFG) begin
                        // A zero-length run skips RUN so result keeps its old value
                        state_nxt = (run_lat == '0) ? DONE : RUN;
                    end
                end
            end
            RUN: begin
                fab_cmd    = CMD_RUN;
                fab_nibble = data_in;
                if (run_cnt == run_lat - RUN_W'(1)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_diferential_muxpga_loader.sv
// Purpose: self-checking bench for diferential_muxpga_loader with a queue-based expected trace.
// Latency: each sequence is predicted cycle by cycle from start edge to done.
// Backpressure: random cfg_valid gaps, stray cfg_valid outside LOAD, start held through DONE.
module tb_diferential_muxpga_loader;

    localparam int NCFG  = 24;
    localparam int RUN_W = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [RUN_W-1:0] run_cycles;
    logic             cfg_valid;
    logic [3:0]       cfg_nibble;
    logic             cfg_ready;
    logic [3:0]       data_in;
    logic             fab_reset;
    logic [1:0]       fab_cmd;
    logic [3:0]       fab_nibble;
    logic [7:0]       fab_out;
    logic [7:0]       result;
    logic             busy;
    logic             done;

    int vectors;
    int miscompares;
    logic [7:0] model_result;

    // One cycle of stimulus plus the outputs expected during it
    typedef struct {
        logic       vld;
        logic [3:0] nib;
        logic [3:0] din;
        logic [7:0] fout;
        logic [9:0] exp;
        bit         is_done;
    } step_t;

    diferential_muxpga_loader #(.NCFG(NCFG), .RUN_W(RUN_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .run_cycles (run_cycles),
        .cfg_valid  (cfg_valid),
        .cfg_nibble (cfg_nibble),
        .cfg_ready  (cfg_ready),
        .data_in    (data_in),
        .fab_reset  (fab_reset),
        .fab_cmd    (fab_cmd),
        .fab_nibble (fab_nibble),
        .fab_out    (fab_out),
        .result     (result),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {fab_cmd, fab_nibble, fab_reset, cfg_ready, done, busy}
    function automatic logic [9:0] pack(input logic [1:0] cmd, input logic [3:0] nib,
                                        input logic rst, input logic rdy,
                                        input logic dn, input logic bs);
        return {cmd, nib, rst, rdy, dn, bs};
    endfunction

    function automatic logic [9:0] observed();
        return {fab_cmd, fab_nibble, fab_reset, cfg_ready, done, busy};
    endfunction

    // mode: 0 cfg_valid always high, 1 toggling starting low, 2 random gaps
    task automatic run_seq(input int rc, input int mode, input bit hold,
                           input bit prestarted, input bit force_a5, input string name);
        step_t q[$];
        step_t s;
        int acc;
        int i;
        logic [7:0] exp_result;
        exp_result = model_result;

        // CLEAR: stray cfg_valid must not be accepted
        s.vld = 1'($urandom_range(0, 1)); s.nib = 4'($urandom); s.din = 4'($urandom);
        s.fout = 8'($urandom); s.is_done = 0;
        s.exp = pack(2'd2, 4'h0, 1'b1, 1'b0, 1'b0, 1'b1);
        q.push_back(s);

        acc = 0;
        i = 0;
        while (acc < NCFG) begin
            if (mode == 0)      s.vld = 1'b1;
            else if (mode == 1) s.vld = (i % 2 == 1);
            else                s.vld = 1'($urandom_range(0, 1));
            s.nib = 4'($urandom); s.din = 4'($urandom); s.fout = 8'($urandom);
            s.exp = s.vld ? pack(2'd0, s.nib, 1'b0, 1'b1, 1'b0, 1'b1)
                          : pack(2'd2, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
            if (s.vld) acc++;
            q.push_back(s);
            i++;
        end

        for (int r = 0; r < rc; r++) begin
            s.vld = 1'($urandom_range(0, 1)); s.nib = 4'($urandom);
            s.din = 4'($urandom); s.fout = 8'($urandom);
            if (force_a5 && r == rc - 1) s.fout = 8'hA5;
            s.exp = pack(2'd1, s.din, 1'b0, 1'b0, 1'b0, 1'b1);
            exp_result = s.fout;
            q.push_back(s);
        end

        // DONE: extra cfg_valid offered, must not be accepted
        s.vld = 1'b1; s.nib = 4'($urandom); s.din = 4'($urandom); s.fout = 8'($urandom);
        s.exp = pack(2'd2, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1); s.is_done = 1;
        q.push_back(s);

        if (!prestarted) begin
            @(posedge clk); #1;
            start = 1'b1; run_cycles = RUN_W'(rc); cfg_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (observed() !== pack(2'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
                miscompares++;
                $display("FAIL %s idle-before-start: got %b want %b", name, observed(),
                         pack(2'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
            end
        end

        foreach (q[k]) begin
            @(posedge clk); #1;
            start = hold;
            run_cycles = RUN_W'($urandom);  // latched copy must be used
            cfg_valid = q[k].vld; cfg_nibble = q[k].nib;
            data_in = q[k].din; fab_out = q[k].fout;
            @(negedge clk);
            vectors++;
            if (observed() !== q[k].exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: got %b want %b", name, k + 1, observed(), q[k].exp);
            end
            if (q[k].is_done) begin
                vectors++;
                if (result !== exp_result) begin
                    miscompares++;
                    $display("FAIL %s result-at-done: got %h want %h", name, result, exp_result);
                end
            end
        end

        // Back in IDLE; result held
        @(posedge clk); #1;
        start = hold; run_cycles = RUN_W'(rc); cfg_valid = 1'b1;
        @(negedge clk);
        vectors++;
        if (observed() !== pack(2'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0) || result !== exp_result) begin
            miscompares++;
            $display("FAIL %s idle-after-done: got %b/%h want %b/%h", name, observed(), result,
                     pack(2'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0), exp_result);
        end
        model_result = exp_result;
        if (!hold) start = 1'b0;
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; run_cycles = '0; cfg_valid = 1'b0;
        cfg_nibble = 4'h0; data_in = 4'h0; fab_out = 8'h00;
        model_result = 8'h00;
        #12;
        vectors++;
        if (observed() !== pack(2'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0)) begin
            miscompares++;
            $display("FAIL reset-outputs: got %b want %b", observed(),
                     pack(2'd2, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        vectors++;
        if (result !== 8'h00) begin
            miscompares++;
            $display("FAIL reset-result: got %h want 00", result);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_basic();
        run_seq(3, 0, 1'b0, 1'b0, 1'b1, "basic_rc3");
        vectors++;
        if (result !== 8'hA5) begin
            miscompares++;
            $display("FAIL basic-a5-held: got %h want a5", result);
        end
    endtask

    task automatic test_toggle();
        run_seq(2, 1, 1'b0, 1'b0, 1'b0, "toggle_valid");
    endtask

    task automatic test_zero_run();
        run_seq(0, 0, 1'b0, 1'b0, 1'b0, "zero_run");
        run_seq(0, 2, 1'b0, 1'b0, 1'b0, "zero_run_gaps");
    endtask

    task automatic test_max_run();
        run_seq((1 << RUN_W) - 1, 0, 1'b0, 1'b0, 1'b0, "max_run");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            run_seq(int'($urandom_range(0, 12)), 2, 1'b0, 1'b0, 1'b0, "random_seq");
        end
    endtask

    task automatic test_reset_mid_load();
        @(posedge clk); #1;
        start = 1'b1; run_cycles = 8'd5; cfg_valid = 1'b1;
        @(posedge clk); #1;             // CLEAR
        start = 1'b0;
        repeat (10) @(posedge clk);     // into the 10th LOAD cycle
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || fab_cmd !== 2'd2 || done !== 1'b0 || result !== 8'h00) begin
            miscompares++;
            $display("FAIL reset-mid-load: got busy=%b cmd=%0d done=%b result=%h want 0/2/0/00",
                     busy, fab_cmd, done, result);
        end
        model_result = 8'h00;
        @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL post-reset-quiet: got done=%b busy=%b want 0/0", done, busy);
            end
        end
        cfg_valid = 1'b0;
        run_seq(4, 2, 1'b0, 1'b0, 1'b0, "restart_after_reset");
    endtask

    task automatic test_start_held();
        run_seq(4, 0, 1'b1, 1'b0, 1'b0, "start_held_first");
        run_seq(4, 2, 1'b0, 1'b1, 1'b0, "start_held_second");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_toggle();
        test_zero_run();
        test_max_run();
        test_random();
        test_reset_mid_load();
        test_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/diferential_muxpga_loader.md
DIFERENTIAL_MUXPGA_LOADER -- requirements
Module: diferential_muxpga_loader

Interface
REQ-001 SHALL have parameter NCFG, default 24, number of config nibbles per bitstream (fabric shift chain depth).
REQ-002 SHALL have parameter RUN_W, default 8, width of run-cycle count.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock, shared with the fabric.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  begin a load-and-run sequence; sampled in IDLE only.
REQ-007 run_cycles  input  RUN_W  enabled fabric cycles; latched on accepted start.
REQ-008 cfg_valid  input  1  config nibble available.
REQ-009 cfg_nibble  input  4  config nibble; first nibble accepted ends deepest in the chain.
REQ-010 cfg_ready  output  1  loader accepts cfg_nibble this cycle.
REQ-011 data_in  input  4  operand driven to fabric row 0 during RUN.
REQ-012 fab_reset  output  1  active-high synchronous reset to the fabric.
REQ-013 fab_cmd  output  2  fabric command: 0 shift config, 1 run, 2 hold.
REQ-014 fab_nibble  output  4  fabric nibble input.
REQ-015 fab_out  input  8  fabric output byte.
REQ-016 result  output  8  captured fabric output.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done  output  1  one-cycle completion pulse.

Function
REQ-019 FSM states SHALL be IDLE, CLEAR, LOAD, RUN, DONE.
REQ-020 IDLE: start=1 at an edge -> CLEAR next cycle; latch run_cycles; start in any other state ignored.
REQ-021 CLEAR SHALL last exactly 1 cycle with fab_reset=1, fab_cmd=2, then -> LOAD.
REQ-022 LOAD: cfg_ready=1; fab_cmd=0 and fab_nibble=cfg_nibble when cfg_valid=1, else fab_cmd=2, fab_nibble=0.
REQ-023 LOAD SHALL count accepted nibbles (cfg_valid&cfg_ready); after the NCFG-th acceptance -> RUN, or -> DONE if latched run_cycles=0.
REQ-024 Extra cfg_valid after NCFG accepted SHALL NOT be accepted (cfg_ready=0 outside LOAD).
REQ-025 RUN: fab_cmd=1, fab_nibble=data_in, for exactly latched run_cycles cycles, then -> DONE.
REQ-026 RUN: result SHALL load fab_out at the edge ending each RUN cycle; final value = fab_out present during last RUN cycle.
REQ-027 run_cycles=0 SHALL leave result unchanged from its previous value.
REQ-028 DONE: done=1, fab_cmd=2, exactly 1 cycle, then -> IDLE; start seen in DONE ignored.
REQ-029 IDLE: fab_cmd=2, fab_nibble=0, fab_reset=0, cfg_ready=0, done=0.
REQ-030 Outputs fab_cmd, fab_reset, cfg_ready, busy, done SHALL be combinational from state and inputs listed; result SHALL be registered.
REQ-031 Counters SHALL not wrap: run_cycles=2^RUN_W-1 gives exactly that many RUN cycles.
REQ-032 Total sequence latency with continuous cfg_valid SHALL be 1+NCFG+run_cycles+1 cycles from start edge to done.

Reset
REQ-033 reset=0 SHALL asynchronously force state IDLE, counters 0, result 8'h00, run_cycles latch 0.
REQ-034 Reset mid-LOAD or mid-RUN SHALL abort with no done pulse; fab_cmd=2 immediately.
REQ-035 After reset release, first edge with start=1 SHALL begin a full sequence including CLEAR.

Verification
REQ-036 start, run_cycles=3, cfg_valid always high -> CLEAR 1 cycle, 24 cycles fab_cmd=0, 3 cycles fab_cmd=1, done at cycle 29.
REQ-037 cfg_valid toggled 1/0 in LOAD -> fab_cmd alternates 0/2; exactly 24 nibbles shifted, LOAD lasts 48 cycles.
REQ-038 run_cycles=0 -> LOAD then DONE directly; no fab_cmd=1 cycle; result unchanged.
REQ-039 fab_out=8'hA5 during last RUN cycle -> result=8'hA5 at done, held in IDLE.
REQ-040 reset=0 at cycle 10 of LOAD -> busy=0, fab_cmd=2 immediately, no done; next start restarts at CLEAR.
REQ-041 start held high through DONE -> single sequence plus new one beginning only from IDLE.
